decode_issue_queue: RTL and testbench
=====================================

# decode_issue_queue

Elastic buffer between the decode stage and execute/issue. It accepts `decode_data_t` records from decode over a valid/ready handshake and holds up to DEPTH of them in program order. It presents them to execute over a second valid/ready handshake, so multicycle stalls in execute do not back-propagate combinationally into decode. It also serializes privileged and exception-raising instructions, and drops all contents on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  discard every held entry and clear the serialize lock.
- `in_valid`  in  1  decode presents a record.
- `in_ready`  out  1  queue accepts the record this cycle.
- `in_data`  in  `$bits(decode_data_t)`  decoded record from decode.
- `out_valid`  out  1  head record is valid.
- `out_ready`  in  1  execute consumes the head this cycle.
- `out_data`  out  `$bits(decode_data_t)`  head record.
- `count`  out  CNT_W  number of occupied entries.
- `serial_lock`  out  1  a serializing record is in flight.

## Operation
- Storage: circular array of DEPTH records, with `wr_ptr`/`rd_ptr` of `log2(DEPTH)` bits.
  - Pointers wrap modulo DEPTH.
  - `count` is kept as a separate register.
- Enqueue fires when `in_valid && in_ready`. It writes `in_data` at `wr_ptr` and increments `wr_ptr`.
- Dequeue fires when `out_valid && out_ready`. It increments `rd_ptr`.
- `in_ready = (count != DEPTH) && !serial_lock`.
  - This is not dequeue-aware: a full queue refuses input even if the head drains in the same cycle.
- `out_valid = (count != 0)`. `out_data` is the record at `rd_ptr`.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both fire.
- Serializing record: `instr.ctl.is_eret | instr.ctl.is_sys | instr.ctl.is_bp | instr.ctl.cp0write | exception_ri`.
- Serialize FSM has two states, OPEN and LOCKED:
  - OPEN → LOCKED when a serializing record is enqueued.
  - LOCKED → OPEN when that record is dequeued. It is the youngest entry, so this is the dequeue that leaves `count == 0`.
  - `serial_lock` is 1 in LOCKED.
- `flush` has priority over everything in the same cycle:
  - Next `count` = 0 and both pointers = 0.
  - FSM goes to OPEN.
  - Any enqueue or dequeue in that cycle is discarded.
- Reset values: `count` = 0, pointers = 0, FSM = OPEN, storage = 0.
  - Hence `out_valid` = 0, `in_ready` = 1, `serial_lock` = 0, `out_data` = 0.

## Timing
- Without bypass, an enqueue at edge N drives `out_valid` = 1 with that record from edge N onward, i.e. it is visible in cycle N+1. Minimum latency is 1 cycle.
- Throughput is one record per cycle in each direction while not full, not empty and not locked.
- `in_ready`, `out_valid` and `serial_lock` depend only on registered state, not on same-cycle inputs.
  - Exception: with bypass, `out_valid`/`out_data` also depend on `in_valid`/`in_data`.
- A serializing record blocks the next enqueue from the cycle after it is accepted. Input reopens the cycle after it is dequeued.
- Deasserting `resetn` mid-operation clears all state immediately; held records are lost.
- Once `out_valid` is high, `out_data` holds stable until dequeue or flush.

## Configuration
- `DECODE_ISSUE_BYPASS_EN` defined:
  - When `count == 0`, the FSM is OPEN and `in_valid && out_ready && !flush`, then `out_valid` = 1 and `out_data` = `in_data` combinationally.
  - The record is consumed the same cycle and is not written to storage. `count` stays 0.
  - A bypassed serializing record does not enter LOCKED, because it has already issued.
  - `flush` forces bypass `out_valid` to 0.
- Undefined: no combinational path from `in_*` to `out_*`. Minimum latency is 1 cycle.

## Test plan
- Reset, then enqueue 4 records (pcplus4 = 0x4, 0x8, 0xC, 0x10) with `out_ready` = 0:
  - `count` = 4 and `in_ready` = 0.
  - Then `out_ready` = 1 drains them in order 0x4, 0x8, 0xC, 0x10, one per cycle.
- Full queue, `in_valid` = 1 and `out_ready` = 1 in the same cycle:
  - Dequeue occurs, enqueue is refused, `count` goes 4 → 3.
  - The next cycle accepts the record.
- Enqueue a SYSCALL record (`is_sys` = 1) followed by an ADDU with `out_ready` = 0:
  - `serial_lock` = 1 and ADDU is held off.
  - After SYSCALL dequeues, `in_ready` returns to 1 the next cycle and ADDU enters.
- `count` = 3 with `flush`, `in_valid` and `out_ready` all 1 in one cycle:
  - Next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1, and nothing was issued from the flushed contents after that edge.
- With `DECODE_ISSUE_BYPASS_EN`, empty queue, `in_valid` = `out_ready` = 1, pcplus4 = 0x100:
  - `out_valid` = 1 and `out_data.pcplus4` = 0x100 in the same cycle, `count` stays 0.
  - Without the macro, the record appears one cycle later.
- Assert `resetn` = 0 mid-drain with `count` = 2:
  - `out_valid` = 0 and `count` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: elastic in-order buffer between decode and execute.
// Holds up to DEPTH decoded records, serializes privileged/exception records,
// and drops everything on flush.
// Optional feature macro: DECODE_ISSUE_BYPASS_EN (empty-queue same-cycle bypass).

package decode_issue_pkg;

    typedef struct packed {
        logic is_eret;
        logic is_sys;
        logic is_bp;
        logic cp0write;
        logic regwrite;
        logic memread;
        logic memwrite;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] raw;
    } instr_t;

    typedef struct packed {
        instr_t      instr;
        logic        exception_ri;
        logic [31:0] pcplus4;
    } decode_data_t;

endpackage

module decode_issue_queue
    import decode_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  decode_data_t     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output decode_data_t     out_data,
    output logic [CNT_W-1:0] count,
    output logic             serial_lock
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        StOpen,
        StLocked
    } ser_state_t;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    decode_data_t     r_mem [DEPTH];
    ser_state_t       r_state;
    logic             r_serial_lock;

    logic             w_in_ready;
    logic             w_bypass;
    logic             w_enq;
    logic             w_deq;
    logic             w_is_serial;
    logic [CNT_W-1:0] w_count_nxt;

    // Ready depends only on registered state; a full queue refuses even if the head drains now.
    assign w_in_ready = (r_count != CNT_W'(DEPTH)) && !r_serial_lock;

`ifdef DECODE_ISSUE_BYPASS_EN
    // Empty and open: hand the incoming record straight to execute without storing it.
    assign w_bypass = (r_count == '0) && (r_state == StOpen) && in_valid && out_ready && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Flush discards any handshake in its cycle; a bypassed record never enters storage.
    assign w_enq = in_valid && w_in_ready && !w_bypass && !flush;
    assign w_deq = (r_count != '0) && out_ready && !flush;

    assign w_is_serial = in_data.instr.ctl.is_eret | in_data.instr.ctl.is_sys |
                         in_data.instr.ctl.is_bp | in_data.instr.ctl.cp0write |
                         in_data.exception_ri;

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_count != '0) || w_bypass;
    assign out_data    = w_bypass ? in_data : r_mem[r_rd_ptr];
    assign count       = r_count;
    assign serial_lock = r_serial_lock;

    // Occupancy next-state: simultaneous enqueue and dequeue leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Record storage; cleared on reset so an idle head reads as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enq) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Serialize FSM: a serializing record is always the youngest entry, so the dequeue that
    // empties the queue is the one that retires it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StOpen;
            r_serial_lock <= 1'b0;
        end else if (flush) begin
            r_state       <= StOpen;
            r_serial_lock <= 1'b0;
        end else begin
            unique case (r_state)
                StOpen: begin
                    if (w_enq && w_is_serial) begin
                        r_state       <= StLocked;
                        r_serial_lock <= 1'b1;
                    end
                end
                StLocked: begin
                    if (w_deq && (r_count == CNT_W'(1))) begin
                        r_state       <= StOpen;
                        r_serial_lock <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= StOpen;
                    r_serial_lock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Scoreboard bench for decode_issue_queue: driver pushes expected records, a negedge
// monitor pops and compares every issued record. Honours DECODE_ISSUE_BYPASS_EN.

module tb_decode_issue_queue;
    import decode_issue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    decode_data_t     in_data;
    logic             out_valid;
    logic             out_ready;
    decode_data_t     out_data;
    logic [CNT_W-1:0] count;
    logic             serial_lock;

    int checks   = 0;
    int failures = 0;

    decode_data_t sb [$];

    decode_issue_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .serial_lock (serial_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic decode_data_t mk(input logic [31:0] pc, input logic sys);
        decode_data_t d;
        d                    = '0;
        d.pcplus4            = pc;
        d.instr.raw          = sys ? 32'h0000_000c : 32'h0022_1821;
        d.instr.ctl.is_sys   = sys;
        d.instr.ctl.regwrite = !sys;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enqueue one record known (by hand) to be accepted at the next edge.
    task automatic push(input logic [31:0] pc, input logic sys);
        in_valid = 1'b1;
        in_data  = mk(pc, sys);
        sb.push_back(mk(pc, sys));
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: every dequeue handshake must match the oldest expected record.
    always @(negedge clk) begin
        if (resetn && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                failures++;
                checks++;
                $display("FAIL unexpected_issue: got pc %0h expected none", out_data.pcplus4);
            end else begin
                check("issue_data", 128'(out_data), 128'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_count", 128'(count), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_serial_lock", 128'(serial_lock), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        resetn = 1'b1;
        step();

        // Fill to DEPTH, then drain in order.
        for (int i = 1; i <= 4; i++) push(32'(4 * i), 1'b0);
        check("fill_count", 128'(count), 128'(4));
        check("fill_in_ready", 128'(in_ready), 128'(0));
        check("fill_out_valid", 128'(out_valid), 128'(1));
        check("fill_head", 128'(out_data.pcplus4), 128'(32'h4));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        check("drain_count", 128'(count), 128'(0));
        check("drain_out_valid", 128'(out_valid), 128'(0));
        check("drain_sb_empty", 128'(sb.size()), 128'(0));

        // Full queue with simultaneous in/out: dequeue only, then accept next cycle.
        for (int i = 0; i < 4; i++) push(32'h14 + 32'(4 * i), 1'b0);
        in_valid  = 1'b1;
        in_data   = mk(32'h24, 1'b0);
        out_ready = 1'b1;
        #1;
        check("full_refuse", 128'(in_ready), 128'(0));
        step();
        check("full_count_4to3", 128'(count), 128'(3));
        check("full_reopen", 128'(in_ready), 128'(1));
        sb.push_back(mk(32'h24, 1'b0));
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("full_accept_count", 128'(count), 128'(4));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        check("full_drain_count", 128'(count), 128'(0));

        // SYSCALL locks input; ADDU enters the cycle after SYSCALL leaves.
        push(32'h40, 1'b1);
        in_valid = 1'b1;
        in_data  = mk(32'h44, 1'b0);
        check("ser_lock", 128'(serial_lock), 128'(1));
        check("ser_in_ready", 128'(in_ready), 128'(0));
        step();
        check("ser_held_count", 128'(count), 128'(1));
        sb.push_back(mk(32'h44, 1'b0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ser_unlock", 128'(serial_lock), 128'(0));
        check("ser_reopen", 128'(in_ready), 128'(1));
        check("ser_empty", 128'(count), 128'(0));
        step();
        in_valid = 1'b0;
        check("ser_addu_in", 128'(count), 128'(1));
        check("ser_addu_head", 128'(out_data.pcplus4), 128'(32'h44));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ser_drain", 128'(count), 128'(0));

        // Flush with count 3 (locked) while enqueue and dequeue are also requested.
        push(32'h50, 1'b0);
        push(32'h54, 1'b0);
        push(32'h58, 1'b1);
        check("flush_pre_count", 128'(count), 128'(3));
        check("flush_pre_lock", 128'(serial_lock), 128'(1));
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(32'h5c, 1'b0);
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_count", 128'(count), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        check("flush_lock", 128'(serial_lock), 128'(0));
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;

        // Empty-queue latency: same cycle with bypass, one cycle later without.
        in_valid  = 1'b1;
        in_data   = mk(32'h100, 1'b0);
        out_ready = 1'b1;
        sb.push_back(mk(32'h100, 1'b0));
        #1;
`ifdef DECODE_ISSUE_BYPASS_EN
        check("byp_out_valid", 128'(out_valid), 128'(1));
        check("byp_out_pc", 128'(out_data.pcplus4), 128'(32'h100));
        step();
        in_valid = 1'b0;
        check("byp_count", 128'(count), 128'(0));
        check("byp_after_valid", 128'(out_valid), 128'(0));
`else
        check("lat_out_valid", 128'(out_valid), 128'(0));
        step();
        in_valid = 1'b0;
        check("lat_count", 128'(count), 128'(1));
        check("lat_out_pc", 128'(out_data.pcplus4), 128'(32'h100));
        step();
        check("lat_drain", 128'(count), 128'(0));
`endif
        out_ready = 1'b0;
        step();
        check("lat_sb_empty", 128'(sb.size()), 128'(0));

        // Asynchronous reset mid-drain with two entries held.
        push(32'h200, 1'b0);
        push(32'h204, 1'b0);
        push(32'h208, 1'b0);
        out_ready = 1'b1;
        step();
        check("arst_pre_count", 128'(count), 128'(2));
        #1;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_count", 128'(count), 128'(0));
        check("arst_out_data", 128'(out_data), 128'(0));
        sb.delete();
        out_ready = 1'b0;
        #1;
        resetn = 1'b1;
        step();
        check("arst_in_ready", 128'(in_ready), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
